axi_fir_mac: RTL
================

# axi_fir_mac

Parametrised successor to the fixed 32-tap, 14-bit AXI FIR slave. It is a single-channel, time-multiplexed FIR filter with a runtime-loadable coefficient bank behind an AXI4-Lite slave. Samples arrive on a valid-qualified input and results leave on a valid-qualified output. One multiplier is shared across all taps, so the block sits between ADC capture and DAC/DMA logic in the PL, under PetaLinux driver control.

## Interface
Parameters:
- NTAPS, 32, number of taps, 2..256
- DATA_WIDTH, 14, signed sample width in and out
- COEF_WIDTH, 14, signed coefficient width
- SHIFT, 13, arithmetic right shift applied to the accumulator before saturation, 0..31

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  reset, asynchronous, active-low
- s_axi_awaddr  in  5  write address
- s_axi_awvalid / s_axi_awready  in/out  1  write address handshake
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  write strobes
- s_axi_wvalid / s_axi_wready  in/out  1  write data handshake
- s_axi_bresp  out  2  write response
- s_axi_bvalid / s_axi_bready  out/in  1  write response handshake
- s_axi_araddr  in  5  read address
- s_axi_arvalid / s_axi_arready  in/out  1  read address handshake
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid / s_axi_rready  out/in  1  read data handshake
- sample_in  in  DATA_WIDTH  signed input sample
- sample_valid  in  1  sample_in is valid this cycle
- sample_out  out  DATA_WIDTH  signed filtered sample
- sample_out_valid  out  1  one-cycle strobe for sample_out

## Operation
Register map (byte offsets):
- 0x00 CTRL, RW
  - bit0 ENABLE.
  - bit1 CLEAR: write-1, self-clearing. Zeroes the delay line and aborts any MAC in progress without producing an output.
- 0x04 STATUS
  - bit0 BUSY, RO.
  - bit1 OVERRUN, sticky, write-1-to-clear.
- 0x08 COEF_IDX, RW, 8 bits. Reads return the current index.
- 0x0C COEF_DATA
  - Write stores wdata[COEF_WIDTH-1:0] into coef[COEF_IDX], then COEF_IDX increments (wraps NTAPS-1 → 0).
  - Read returns coef[COEF_IDX], sign-extended to 32 bits.
- 0x10 LAST_OUT, RO: last sample_out, sign-extended.
- 0x14 OUT_CNT, RO: 32-bit count of produced outputs, wraps.

Register write rules:
- wstrb is ignored; every write is a full 32-bit write.
- COEF_IDX writes of NTAPS or more are clamped to NTAPS-1.

AXI-Lite handshake:
- A write is accepted only when awvalid, wvalid and !bvalid are all true. awready and wready pulse together for one cycle; bvalid rises the next cycle and holds until bready.
- A read is accepted when arvalid and !rvalid. arready pulses for one cycle; rvalid and rdata follow the next cycle and hold until rready.
- Unmapped addresses: writes are dropped, reads return 0, response is OKAY.
- A COEF_DATA write while BUSY gets SLVERR (2'b10) and is discarded; COEF_IDX does not move.

FSM:
- IDLE → (sample_valid & ENABLE) → MAC.
  - On entry: delay line shifts (x[0] ← sample_in), acc ← 0, tap ← 0.
- MAC: acc += x[tap] * coef[tap] each cycle; tap counts 0..NTAPS-1. After the last tap → OUT.
- OUT: sample_out ← sat(acc >>> SHIFT); sample_out_valid = 1; LAST_OUT updated; OUT_CNT incremented → IDLE.
- CLEAR: in any state, returns to IDLE the next cycle.

Overrun and disable:
- sample_valid in MAC or OUT: the sample is dropped and OVERRUN is set.
- sample_valid while !ENABLE: the sample is dropped and OVERRUN is not set.

Arithmetic:
- acc width is DATA_WIDTH + COEF_WIDTH + clog2(NTAPS); signed throughout.
- The shift truncates toward −∞.
- Saturation range is [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].

## Timing
- Reset values: all outputs 0; awready, wready, arready, bvalid, rvalid 0; CTRL, STATUS, COEF_IDX, LAST_OUT, OUT_CNT 0; coefficients and delay line 0; FSM in IDLE.
- Latency from the accepted sample_valid edge to sample_out_valid is NTAPS+1 cycles.
- Minimum sample spacing is NTAPS+2 cycles. A sample may arrive in the cycle after OUT.
- BUSY is high in MAC and OUT.
- Same-cycle CLEAR write and sample_valid: CLEAR wins and the sample is dropped.
- Same-cycle AXI write of OVERRUN-clear and a new overrun event: the set wins.
- ARESETN asserted mid-operation: all state clears immediately and no output is produced.

## Test plan
- Reset check: hold ARESETN low for 200 ns → every AXI and sample output is 0; reads of CTRL, STATUS and OUT_CNT all return 0.
- Impulse response (SHIFT=0): load coef[k]=k+1 via COEF_IDX=0 and 32 COEF_DATA writes; ENABLE; apply sample 1 followed by 31 zeros, each spaced 34 cycles → outputs 1,2,…,32; OUT_CNT=32; each output NTAPS+1 cycles after its sample.
- Saturation (defaults): all coefs 8191; apply 32 samples of 8191 → final output 8191. Repeat with −8192 samples → output −8192.
- Overrun: apply a sample, then a second sample 5 cycles later → only one output; STATUS=0x2 once idle. Write 0x2 to STATUS → reads 0.
- Busy coefficient write: write COEF_DATA during MAC → bresp=SLVERR; coef unchanged and COEF_IDX unchanged on readback.
- CLEAR mid-MAC: assert CLEAR 10 cycles after a sample → no sample_out_valid; BUSY drops; next impulse reproduces the impulse-response values from a zero history.

Source files
------------

// File: rtl/axi_fir_mac_if.sv
// AXI4-Lite slave bus for axi_fir_mac.
// Signals: write address (awaddr/awvalid/awready), write data (wdata/wstrb/wvalid/wready),
// write response (bresp/bvalid/bready), read address (araddr/arvalid/arready),
// read data (rdata/rresp/rvalid/rready).
// Modports: master drives requests, slave drives ready/response.
interface axi_fir_mac_if;
  logic [4:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [4:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_fir_mac.sv
// Time-multiplexed FIR filter with one shared multiplier and an AXI4-Lite
// coefficient/control bank.
// Ports:
//   ACLK, ARESETN     clock, asynchronous active-low reset
//   s_axi             AXI4-Lite slave (CTRL, STATUS, COEF_IDX, COEF_DATA, LAST_OUT, OUT_CNT)
//   sample_in/valid   signed input sample, valid-qualified
//   sample_out/valid  signed filtered sample, one-cycle strobe
module axi_fir_mac #(
  parameter int NTAPS      = 32,
  parameter int DATA_WIDTH = 14,
  parameter int COEF_WIDTH = 14,
  parameter int SHIFT      = 13
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  axi_fir_mac_if.slave                 s_axi,
  input  logic signed [DATA_WIDTH-1:0] sample_in,
  input  logic                         sample_valid,
  output logic signed [DATA_WIDTH-1:0] sample_out,
  output logic                         sample_out_valid
);
  localparam int IW = $clog2(NTAPS);
  localparam int PW = DATA_WIDTH + COEF_WIDTH;
  localparam int AW = PW + $clog2(NTAPS);
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;
  state_t r_state, w_state_nx;

  logic                         r_enable, r_overrun;
  logic [7:0]                   r_coef_idx;
  logic signed [COEF_WIDTH-1:0] r_coef [NTAPS];
  logic signed [DATA_WIDTH-1:0] r_x    [NTAPS];
  logic [IW-1:0]                r_tap;
  logic signed [AW-1:0]         r_acc;
  logic signed [DATA_WIDTH-1:0] r_sample_out, r_last_out;
  logic                         r_out_valid;
  logic [31:0]                  r_out_cnt;
  logic                         r_awready, r_bvalid, r_arready, r_rvalid;
  logic [1:0]                   r_bresp;
  logic [31:0]                  r_rdata;

  logic w_wr, w_rd, w_busy, w_start, w_clear, w_last_tap, w_ovr_set;
  logic w_wr_ctrl, w_wr_status, w_wr_idx, w_wr_cdata, w_coef_wr, w_coef_err;
  logic signed [PW-1:0]         w_prod;
  logic signed [AW-1:0]         w_prod_ext, w_shr;
  logic signed [DATA_WIDTH-1:0] w_sat;
  logic signed [COEF_WIDTH-1:0] w_coef_rd;
  logic [31:0]                  w_rdata;
  logic                         w_unused;

  assign w_unused = &{1'b0, s_axi.wstrb};

  // The write commits in the cycle awready/wready are shown, so bvalid follows one cycle later.
  assign w_wr        = r_awready & s_axi.awvalid & s_axi.wvalid;
  assign w_rd        = r_arready & s_axi.arvalid;
  assign w_wr_ctrl   = w_wr && (s_axi.awaddr == 5'h00);
  assign w_wr_status = w_wr && (s_axi.awaddr == 5'h04);
  assign w_wr_idx    = w_wr && (s_axi.awaddr == 5'h08);
  assign w_wr_cdata  = w_wr && (s_axi.awaddr == 5'h0C);
  assign w_busy      = (r_state != S_IDLE);
  assign w_coef_wr   = w_wr_cdata & ~w_busy;
  assign w_coef_err  = w_wr_cdata & w_busy;
  assign w_clear     = w_wr_ctrl & s_axi.wdata[1];
  assign w_start     = (r_state == S_IDLE) & sample_valid & r_enable & ~w_clear;
  assign w_ovr_set   = sample_valid & w_busy;
  assign w_last_tap  = (r_tap == IW'(NTAPS-1));

  assign w_prod     = r_x[r_tap] * r_coef[r_tap];
  assign w_prod_ext = {{(AW-PW){w_prod[PW-1]}}, w_prod};
  assign w_shr      = r_acc >>> SHIFT;
  assign w_coef_rd  = r_coef[r_coef_idx[IW-1:0]];

  always_comb begin
    w_sat = w_shr[DATA_WIDTH-1:0];
    if (w_shr > SAT_MAX)      w_sat = SAT_MAX[DATA_WIDTH-1:0];
    else if (w_shr < SAT_MIN) w_sat = SAT_MIN[DATA_WIDTH-1:0];
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= S_IDLE;
    else          r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nx = S_MAC;
      S_MAC:   if (w_last_tap) w_state_nx = S_OUT;
      S_OUT:   w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
    if (w_clear) w_state_nx = S_IDLE;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int unsigned i = 0; i < NTAPS; i++) r_x[i] <= '0;
      r_acc        <= '0;
      r_tap        <= '0;
      r_sample_out <= '0;
      r_last_out   <= '0;
      r_out_valid  <= 1'b0;
      r_out_cnt    <= '0;
    end else begin
      if (w_clear) begin
        for (int unsigned i = 0; i < NTAPS; i++) r_x[i] <= '0;
      end else if (w_start) begin
        for (int unsigned i = NTAPS-1; i > 0; i--) r_x[i] <= r_x[i-1];
        r_x[0] <= sample_in;
      end
      if (w_start) begin
        r_acc <= '0;
        r_tap <= '0;
      end else if (r_state == S_MAC) begin
        r_acc <= r_acc + w_prod_ext;
        r_tap <= r_tap + 1'b1;
      end
      r_out_valid <= (r_state == S_OUT) & ~w_clear;
      if ((r_state == S_OUT) && !w_clear) begin
        r_sample_out <= w_sat;
        r_last_out   <= w_sat;
        r_out_cnt    <= r_out_cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_enable   <= 1'b0;
      r_overrun  <= 1'b0;
      r_coef_idx <= '0;
      for (int unsigned i = 0; i < NTAPS; i++) r_coef[i] <= '0;
    end else begin
      if (w_wr_ctrl) r_enable <= s_axi.wdata[0];
      r_overrun <= (r_overrun & ~(w_wr_status & s_axi.wdata[1])) | w_ovr_set;
      if (w_wr_idx) begin
        r_coef_idx <= (s_axi.wdata >= 32'(NTAPS)) ? 8'(NTAPS-1) : s_axi.wdata[7:0];
      end else if (w_coef_wr) begin
        r_coef[r_coef_idx[IW-1:0]] <= s_axi.wdata[COEF_WIDTH-1:0];
        r_coef_idx <= (r_coef_idx == 8'(NTAPS-1)) ? 8'd0 : r_coef_idx + 8'd1;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (s_axi.araddr)
      5'h00:   w_rdata = {31'd0, r_enable};
      5'h04:   w_rdata = {30'd0, r_overrun, w_busy};
      5'h08:   w_rdata = {24'd0, r_coef_idx};
      5'h0C:   w_rdata = {{(32-COEF_WIDTH){w_coef_rd[COEF_WIDTH-1]}}, w_coef_rd};
      5'h10:   w_rdata = {{(32-DATA_WIDTH){r_last_out[DATA_WIDTH-1]}}, r_last_out};
      5'h14:   w_rdata = r_out_cnt;
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_awready <= s_axi.awvalid & s_axi.wvalid & ~r_bvalid & ~r_awready;
      if (w_wr) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_coef_err ? 2'b10 : 2'b00;
      end else if (r_bvalid && s_axi.bready) begin
        r_bvalid <= 1'b0;
      end
      r_arready <= s_axi.arvalid & ~r_rvalid & ~r_arready;
      if (w_rd) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata;
      end else if (r_rvalid && s_axi.rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign s_axi.awready    = r_awready;
  assign s_axi.wready     = r_awready;
  assign s_axi.bvalid     = r_bvalid;
  assign s_axi.bresp      = r_bresp;
  assign s_axi.arready    = r_arready;
  assign s_axi.rvalid     = r_rvalid;
  assign s_axi.rdata      = r_rdata;
  assign s_axi.rresp      = 2'b00;
  assign sample_out       = r_sample_out;
  assign sample_out_valid = r_out_valid;
endmodule
